or_unit_rr_arbiter: RTL and testbench
=====================================

// Module: or_unit_rr_arbiter
// PURPOSE
//  Shares one 4-bit bitwise-OR datapath among N_REQ requesters.
//  - Arbitrates requests round-robin and latches the winner's operands.
//  - Computes A|B in a registered stage.
//  - Returns result plus requester ID with a valid/ready handshake.
//  - Sits between the requester clients and the shared OR unit; one op in flight.
// PARAMETERS
//  N_REQ  4  number of requesters (2..8)
//  W      4  operand/result width in bits
//  ID_W   2  width of res_id; must equal clog2(N_REQ)
// PORTS
//  clk      in   1          rising-edge clock
//  rst_n    in   1          async active-low reset
//  req      in   N_REQ      per-requester request; held until matching gnt seen
//  a_flat   in   N_REQ*W    operand A; requester i at [i*W +: W]
//  b_flat   in   N_REQ*W    operand B; same packing
//  gnt      out  N_REQ      one-hot, 1-cycle pulse: operands captured
//  res      out  W          registered result A|B
//  res_id   out  ID_W       index of requester owning res
//  res_vld  out  1          result valid; held until res_rdy
//  res_rdy  in   1          consumer accepts result
//  busy     out  1          high in any state other than IDLE
// BEHAVIOUR
//  Reset values (asynchronous, immediate, any state):
//  - gnt=0, res=0, res_id=0, res_vld=0, busy=0
//  - state=IDLE, rr pointer ptr=0, operand registers=0
//  FSM:
//  - IDLE: if |req, winner = first set req[i] searching ptr, ptr+1, ... mod N_REQ.
//    Next edge: gnt=onehot(winner); latch a/b slices; latch winner id; ptr=winner+1 mod N_REQ.
//    Wrap N_REQ-1 -> 0. Next state EXEC. If no req: stay IDLE, no change.
//  - EXEC: gnt=0. Next edge: res=opA|opB; res_id=latched id; res_vld=1.
//    Next state RESP. req ignored.
//  - RESP: hold res/res_id/res_vld stable while res_rdy=0.
//    On edge with res_rdy=1: res_vld=0, state IDLE. res/res_id keep last value.
//  Timing: req sampled at edge t -> gnt at t+1 -> res_vld at t+2.
//  - Minimum 3 cycles per op (IDLE->EXEC->RESP->IDLE with res_rdy=1).
//  - Next grant earliest at t+4.
//  Rules:
//  - busy = (state != IDLE), combinational from state.
//  - res_rdy in IDLE/EXEC is ignored; no result is consumed.
//  - req deasserted before the sampling edge is not granted; no penalty.
//  - A requester must drop req for one cycle after gnt unless it has a new op.
//    A held req is re-arbitrated as a new request.
//  - Requesters' operand changes after gnt do not affect the in-flight result.
//  - Simultaneous req: exactly one gnt bit. Never two gnt bits, never gnt outside IDLE->EXEC.
//  - Reset mid-operation aborts the op. The result is lost, no res_vld.
// CONFIGURATION
//  OR_ARB_FIXED_PRIO_EN:
//  - Defined: fixed priority, lowest index wins; ptr held at 0 and never updated.
//  - Undefined (default): round-robin as above.
//  - All other behaviour and timing are identical.
// TESTING
//  1 Reset: rst_n=0 mid-EXEC -> gnt=0, res_vld=0, busy=0, res=0 with no clock edge.
//    Release rst_n -> IDLE, ptr=0.
//  2 Single op: req=0010, a1=4'b1010, b1=4'b0101, res_rdy=1.
//    -> gnt=0010 at t+1; res=4'b1111, res_id=1, res_vld=1 at t+2; res_vld=0 at t+3.
//  3 Fairness: req=1111 held, res_rdy=1.
//    -> grant order 0,1,2,3,0 (ptr wraps); gnts 3 cycles apart.
//  4 Backpressure: res_rdy=0 for 5 cycles after res_vld.
//    -> res/res_id stable, no gnt, busy=1; res_rdy=1 -> IDLE next edge.
//  5 Late drop: req=1000 deasserted one cycle before IDLE sampling edge.
//    -> no gnt, state stays IDLE, ptr unchanged.
//  6 OR_ARB_FIXED_PRIO_EN defined, req=1001 held -> every gnt=0001, res_id=0.

Source files
------------

// File: rtl/or_unit_rr_arbiter_if.sv
// Handshake/bus bundle between the requester clients and the shared OR arbiter.
interface or_unit_rr_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W     = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] a_flat;
  logic [N_REQ*W-1:0] b_flat;
  logic [N_REQ-1:0]   gnt;
  logic [W-1:0]       res;
  logic [ID_W-1:0]    res_id;
  logic               res_vld;
  logic               res_rdy;
  logic               busy;

  modport master (
    output req, a_flat, b_flat, res_rdy,
    input  gnt, res, res_id, res_vld, busy
  );

  modport slave (
    input  req, a_flat, b_flat, res_rdy,
    output gnt, res, res_id, res_vld, busy
  );
endinterface

// File: rtl/or_unit_rr_arbiter.sv
// Round-robin arbiter in front of one registered W-bit OR unit, one op in flight.
// Define OR_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead.
module or_unit_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 4,
  parameter int ID_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  or_unit_rr_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state, state_nx;
  logic [ID_W-1:0]   ptr, ptr_nx;
  logic [N_REQ-1:0]  gnt_p0, gnt_nx;
  logic [W-1:0]      op_a_p0, op_a_nx;
  logic [W-1:0]      op_b_p0, op_b_nx;
  logic [ID_W-1:0]   id_p0, id_nx;
  logic [W-1:0]      res_p1, res_nx;
  logic [ID_W-1:0]   res_id_p1, res_id_nx;
  logic              vld_p1, vld_nx;

  logic              found;
  int                win;

  // Search starts at ptr and wraps, so the requester just served goes last.
  always_comb begin
    found = 1'b0;
    win   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    ptr_nx    = ptr;
    gnt_nx    = '0;
    op_a_nx   = op_a_p0;
    op_b_nx   = op_b_p0;
    id_nx     = id_p0;
    res_nx    = res_p1;
    res_id_nx = res_id_p1;
    vld_nx    = vld_p1;
    case (state)
      IDLE: begin
        if (found) begin
          gnt_nx  = N_REQ'(1) << win;
          op_a_nx = bus.a_flat[win*W +: W];
          op_b_nx = bus.b_flat[win*W +: W];
          id_nx   = ID_W'(win);
`ifdef OR_ARB_FIXED_PRIO_EN
          ptr_nx  = '0;
`else
          ptr_nx  = (win == N_REQ-1) ? '0 : ID_W'(win + 1);
`endif
          state_nx = EXEC;
        end
      end
      EXEC: begin
        res_nx    = op_a_p0 | op_b_p0;
        res_id_nx = id_p0;
        vld_nx    = 1'b1;
        state_nx  = RESP;
      end
      RESP: begin
        if (bus.res_rdy) begin
          vld_nx   = 1'b0;
          state_nx = IDLE;
        end
      end
      default: begin
        vld_nx   = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  // Stage boundary: arbitration/capture (p0) and OR result (p1) registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt_p0    <= '0;
      op_a_p0   <= '0;
      op_b_p0   <= '0;
      id_p0     <= '0;
      res_p1    <= '0;
      res_id_p1 <= '0;
      vld_p1    <= 1'b0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      gnt_p0    <= gnt_nx;
      op_a_p0   <= op_a_nx;
      op_b_p0   <= op_b_nx;
      id_p0     <= id_nx;
      res_p1    <= res_nx;
      res_id_p1 <= res_id_nx;
      vld_p1    <= vld_nx;
    end
  end

  assign bus.gnt     = gnt_p0;
  assign bus.res     = res_p1;
  assign bus.res_id  = res_id_p1;
  assign bus.res_vld = vld_p1;
  assign bus.busy    = (state != IDLE);

endmodule

// File: tb/tb_or_unit_rr_arbiter.sv
// Randomized bench for or_unit_rr_arbiter against a transaction-level model.
module tb_or_unit_rr_arbiter;
  localparam int N = 4;
  localparam int W = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_ptr = 0;

  or_unit_rr_arbiter_if #(.N_REQ(N), .W(W), .ID_W(IW)) bus ();

  or_unit_rr_arbiter #(.N_REQ(N), .W(W), .ID_W(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] rv, input int p);
    for (int k = 0; k < N; k++)
      if (rv[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    bus.a_flat = N*W'($urandom);
    bus.b_flat = N*W'($urandom);
  endtask

  // Called #1 after an edge with the DUT in IDLE; runs one full operation.
  task automatic do_op(input logic [N-1:0] rv, input bit hold, input int dly);
    int w;
    logic [W-1:0] er;
    w  = pick(rv, m_ptr);
    er = bus.a_flat[w*W +: W] | bus.b_flat[w*W +: W];
    bus.req = rv;
    tick();
    check("gnt", 32'(bus.gnt), 32'(1) << w);
    check("busy_exec", 32'(bus.busy), 32'd1);
    check("vld_exec", 32'(bus.res_vld), 32'd0);
    if (!hold) bus.req = N'($urandom);
    rand_ops();
    bus.res_rdy = 1'($urandom);
    tick();
    check("res", 32'(bus.res), 32'(er));
    check("res_id", 32'(bus.res_id), 32'(w));
    check("vld_resp", 32'(bus.res_vld), 32'd1);
    check("gnt_resp", 32'(bus.gnt), 32'd0);
    bus.res_rdy = 1'b0;
    for (int i = 0; i < dly; i++) begin
      tick();
      check("bp_vld", 32'(bus.res_vld), 32'd1);
      check("bp_res", 32'(bus.res), 32'(er));
      check("bp_id", 32'(bus.res_id), 32'(w));
      check("bp_gnt", 32'(bus.gnt), 32'd0);
      check("bp_busy", 32'(bus.busy), 32'd1);
    end
    bus.res_rdy = 1'b1;
    tick();
    check("vld_done", 32'(bus.res_vld), 32'd0);
    check("busy_done", 32'(bus.busy), 32'd0);
    check("res_keep", 32'(bus.res), 32'(er));
    bus.res_rdy = 1'b0;
`ifdef OR_ARB_FIXED_PRIO_EN
    m_ptr = 0;
`else
    m_ptr = (w + 1) % N;
`endif
  endtask

  initial begin
    bus.req = '0;
    bus.a_flat = '0;
    bus.b_flat = '0;
    bus.res_rdy = 1'b0;
    repeat (2) tick();
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_res", 32'(bus.res), 32'd0);
    check("rst_id", 32'(bus.res_id), 32'd0);
    check("rst_vld", 32'(bus.res_vld), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    m_ptr = 0;

    // Single op from requester 1.
    rand_ops();
    bus.a_flat[1*W +: W] = 4'b1010;
    bus.b_flat[1*W +: W] = 4'b0101;
    do_op(4'b0010, 1'b0, 0);
    check("single_res", 32'(bus.res), 32'hF);
    check("single_id", 32'(bus.res_id), 32'd1);

    // Abort mid-EXEC: outputs clear at once, without a clock edge.
    bus.req = 4'b0100;
    rand_ops();
    tick();
    check("pre_rst_gnt", 32'(bus.gnt), 32'b0100);
    rst_n = 1'b0;
    #1;
    check("arst_gnt", 32'(bus.gnt), 32'd0);
    check("arst_vld", 32'(bus.res_vld), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_res", 32'(bus.res), 32'd0);
    bus.req = '0;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    m_ptr = 0;
    check("post_rst_vld", 32'(bus.res_vld), 32'd0);

    // Fairness: all requesting, held throughout.
    for (int i = 0; i < 5; i++) begin
      rand_ops();
      do_op(4'b1111, 1'b1, 0);
    end

    // Backpressure.
    rand_ops();
    do_op(4'b0110, 1'b0, 5);

    // Late drop: request withdrawn before the sampling edge.
    bus.req = 4'b1000;
    #2;
    bus.req = '0;
    tick();
    check("drop_gnt", 32'(bus.gnt), 32'd0);
    check("drop_busy", 32'(bus.busy), 32'd0);
    tick();
    check("drop_gnt2", 32'(bus.gnt), 32'd0);

    // Two requesters held.
    for (int i = 0; i < 4; i++) begin
      rand_ops();
      do_op(4'b1001, 1'b1, 0);
    end

    // Random operations with idle gaps and random backpressure.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.req = '0;
        tick();
        check("gap_gnt", 32'(bus.gnt), 32'd0);
        check("gap_busy", 32'(bus.busy), 32'd0);
      end
      rand_ops();
      do_op(4'($urandom_range(1, 15)), 1'($urandom), $urandom_range(0, 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
